// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int   PS2_DATA_BITS  = 8;
    localparam int   PS2_FRAME_BITS = 11;
    localparam int   PS2_BIT_CNT_W  = $clog2(PS2_DATA_BITS);
    localparam logic START_LEVEL    = 1'b0;
    localparam logic STOP_LEVEL     = 1'b1;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchronizer plus FILTER_LEN stability filter for one PS/2 pin.
// fall_edge pulses for one cycle in the first cycle the filtered level reads 0.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall_edge
);

    localparam int             CW       = $clog2(FILTER_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Metastability synchronizer; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // Level only follows the pin after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 1'b1;
            cnt       <= '0;
            fall_edge <= 1'b0;
        end else if (sync2 == level) begin
            cnt       <= '0;
            fall_edge <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            level     <= sync2;
            cnt       <= '0;
            fall_edge <= ~sync2;
        end else begin
            cnt       <= cnt + CW'(1);
            fall_edge <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional feature macro: PS2_PARITY_CHECK_EN enables parity checking and parity_err.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic                     clk_level_unused;
    logic                     fall_edge;
    logic                     data_level;
    logic                     data_fall_unused;

    ps2_state_t               state, state_nx;
    logic [PS2_BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [PS2_DATA_BITS-1:0] shift_reg, shift_nx;
    logic [TW-1:0]            tcnt, tcnt_nx;
    logic [7:0]               code_nx;
    logic                     valid_nx;
    logic                     perr_nx;
    logic                     ferr_nx;
`ifdef PS2_PARITY_CHECK_EN
    logic                     par_bit, par_nx;
`endif

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (ps2_clk_in),
        .level     (clk_level_unused),
        .fall_edge (fall_edge)
    );

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (ps2_data_in),
        .level     (data_level),
        .fall_edge (data_fall_unused)
    );

    // Next-state, frame evaluation and watchdog; an edge always beats a timeout.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_reg;
        tcnt_nx    = tcnt;
        code_nx    = scan_code;
        valid_nx   = 1'b0;
        perr_nx    = 1'b0;
        ferr_nx    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_nx     = par_bit;
`endif
        if (fall_edge) begin
            tcnt_nx = '0;
            case (state)
                IDLE: begin
                    if (data_level == START_LEVEL) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end else begin
                        state_nx   = IDLE;
                    end
                end
                DATA: begin
                    shift_nx[bit_cnt] = data_level;
                    if (bit_cnt == PS2_BIT_CNT_W'(PS2_DATA_BITS - 1)) begin
                        state_nx = PARITY;
                    end else begin
                        bit_cnt_nx = bit_cnt + PS2_BIT_CNT_W'(1);
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_nx   = data_level;
`endif
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    if (data_level != STOP_LEVEL) begin
                        ferr_nx = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!odd_parity_ok(shift_reg, par_bit)) begin
                        perr_nx = 1'b1;
`endif
                    end else begin
                        valid_nx = 1'b1;
                        code_nx  = shift_reg;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end else if (state != IDLE) begin
            if (tcnt == TMAX) begin
                state_nx = IDLE;
                tcnt_nx  = '0;
                ferr_nx  = 1'b1;
            end else begin
                tcnt_nx  = tcnt + TW'(1);
            end
        end else begin
            tcnt_nx = '0;
        end
    end

    // State and registered outputs; busy tracks the next state so it drops with the result pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tcnt       <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shift_reg  <= shift_nx;
            tcnt       <= tcnt_nx;
            scan_code  <= code_nx;
            scan_valid <= valid_nx;
            parity_err <= perr_nx;
            frame_err  <= ferr_nx;
            busy       <= (state_nx != IDLE);
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= par_nx;
`endif
        end
    end

endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Synchronous PS/2 device-to-host frame receiver. Oversamples the raw PS/2 clock and data pins in the system clock domain, filters glitches, and detects PS/2 clock falling edges. Captures the 11-bit frame: start bit, 8 data bits LSB first, odd parity, stop bit. Presents a validated scan code with a one-cycle strobe to the keyboard scan-code path; sits directly between the PS/2 pins and scan-code consumption.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive identical samples required before a filtered pin level changes (≥2).
- TIMEOUT_CYCLES, 50000: system clocks allowed between PS/2 falling edges inside a frame before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data_in  in  1  raw PS/2 data pin, asynchronous.
- scan_code  out  8  last accepted data byte; held until the next accepted frame.
- scan_valid  out  1  one-cycle pulse when scan_code is updated.
- parity_err  out  1  one-cycle pulse on parity failure.
- frame_err  out  1  one-cycle pulse on bad stop bit or timeout.
- busy  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Each pin passes through a 2-FF synchronizer, then a FILTER_LEN stability filter. Filtered levels reset to 1.
- fall_edge = filtered ps2_clk 1→0. Data is sampled from filtered ps2_data on the fall_edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_edge with data=0 (start bit), go to DATA with bit_cnt=0. On fall_edge with data=1, stay IDLE and assert no error (spurious edge).
  - DATA: each fall_edge shifts data into shift_reg[bit_cnt], LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on fall_edge, return to IDLE and evaluate the frame:
    - stop=0 → frame_err, no update.
    - else parity mismatch (XOR of 8 data bits and parity bit must be 1) → parity_err, no update.
    - else scan_code←shift_reg and scan_valid.
- Parity failure and stop failure in the same frame: frame_err only.
- Timeout: a counter clears on every fall_edge and increments in non-IDLE states. When it reaches TIMEOUT_CYCLES-1, pulse frame_err and go to IDLE. The counter width is $clog2(TIMEOUT_CYCLES).
- Simultaneous fall_edge and timeout expiry: the edge wins; no abort.
- Reset values: scan_code=8'h00, scan_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counters=0, filtered levels=1.
- Asserting rst_n low mid-frame discards the partial frame. The first frame after release is received normally only if its start edge occurs after release.

## Timing
- Pin-to-filtered latency: 2 + FILTER_LEN clocks.
- scan_valid / parity_err / frame_err are registered and assert on the clock after the stop-bit fall_edge (or timeout) is detected.
- scan_code changes in the same cycle scan_valid is high and is stable thereafter.
- busy rises the cycle after the start-bit edge and falls in the same cycle the result pulse asserts.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- PS2_PARITY_CHECK_EN defined: parity is evaluated as above, and a mismatched frame produces parity_err and no scan_valid.
- PS2_PARITY_CHECK_EN undefined: the parity bit is consumed but ignored, parity_err is tied 0, and frames with a valid stop bit always produce scan_valid.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP),
  - PS2_DATA_BITS=8,
  - PS2_FRAME_BITS=11,
  - START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module ps2_input_filter (synchronizer + FILTER_LEN filter + edge detect) is instantiated twice, once for clock and once for data. The clock instance also exports fall_edge.

## Test plan
- Good frame, byte 8'h1C, parity 0, stop 1 → one scan_valid pulse, scan_code=8'h1C, no error pulses, busy low afterwards.
- Byte 8'h1C with parity 1 (PS2_PARITY_CHECK_EN defined) → parity_err pulse, no scan_valid, scan_code unchanged. Without the macro → scan_valid with 8'h1C.
- Byte 8'hF0, parity 1, stop 0 → frame_err pulse only. A following good 8'hF0 frame → scan_valid, scan_code=8'hF0.
- Stop clocking after 5 data bits → frame_err exactly TIMEOUT_CYCLES clocks after the last edge, busy low. A subsequent good 8'h5A frame (parity 1) is accepted.
- ps2_clk_in low pulse of FILTER_LEN-2 clocks while idle → no state change, busy stays 0.
- rst_n pulsed low after 4 data bits → all outputs at reset values. A good 8'h29 frame after release (parity 0) → scan_code=8'h29.
